// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM encoding, default 24 MHz timing constants and a
// small helper used to size the per-channel counters.
package btn_pkg;

    localparam int SYS_CLK_HZ          = 24_000_000;
    localparam int DEF_DEBOUNCE_CYCLES = SYS_CLK_HZ / 100;   // 10 ms
    localparam int DEF_LONG_CYCLES     = SYS_CLK_HZ;         // 1 s
    localparam int DEF_REPEAT_CYCLES   = SYS_CLK_HZ / 4;     // 250 ms

    typedef enum logic [1:0] {
        BTN_RELEASED = 2'd0,
        BTN_PRESSED  = 2'd1,
        BTN_HELD     = 2'd2
    } btn_fsm_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_reader_if.sv
// btn_reader_if: raw button pins plus the debounced level and event pulses.
// master = btn_reader side, slave = board pins / consuming control logic.
interface btn_reader_if #(
    parameter int N_BTN = 2
);
    logic [N_BTN-1:0] btn_n;
    logic [N_BTN-1:0] btn_state;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;
    logic [N_BTN-1:0] long_pulse;

    modport master (
        input  btn_n,
        output btn_state, press_pulse, release_pulse, long_pulse
    );

    modport slave (
        output btn_n,
        input  btn_state, press_pulse, release_pulse, long_pulse
    );
endinterface

// File: rtl/btn_channel.sv
// btn_channel: one button - 2-flop synchroniser, debounce filter and
// press-classification FSM (RELEASED / PRESSED / HELD).
// Optional macro BTN_AUTOREPEAT_EN adds periodic long_pulse while HELD.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic btn_n,
    output logic btn_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CNT_W = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES) + 1);

    logic             sync0, sync1, s_lvl;
    logic [DB_W-1:0]  db_cnt;
    logic             db_lvl;
    logic             rise, fall;
    btn_fsm_e         state_q, state_d;
    logic [CNT_W-1:0] long_cnt;
    logic             long_hit, rep_hit;
    logic             press_d, release_d, long_d;

    // Two-flop synchroniser; reset value 1 = released pin.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync0 <= 1'b1;
            sync1 <= 1'b1;
        end else begin
            sync0 <= btn_n;
            sync1 <= sync0;
        end
    end

    assign s_lvl = ~sync1;

    // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive mismatches.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            db_cnt <= '0;
            db_lvl <= 1'b0;
        end else if (s_lvl == db_lvl) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_lvl <= ~db_lvl;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // btn_state is the registered copy of db_lvl, so edges are seen here
    // in the same cycle the pulses are computed.
    assign rise = db_lvl & ~btn_state;
    assign fall = ~db_lvl & btn_state;

    // Threshold hit is one count early because the pulse is registered;
    // a simultaneous release suppresses it.
    assign long_hit = (state_q == BTN_PRESSED) && !fall &&
                      (long_cnt == CNT_W'(LONG_CYCLES - 2));

    // FSM state and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= BTN_RELEASED;
            btn_state     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            state_q       <= state_d;
            btn_state     <= db_lvl;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            long_pulse    <= long_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BTN_RELEASED: if (rise)          state_d = BTN_PRESSED;
            BTN_PRESSED:  if (fall)          state_d = BTN_RELEASED;
                          else if (long_hit) state_d = BTN_HELD;
            BTN_HELD:     if (fall)          state_d = BTN_RELEASED;
            default:                         state_d = BTN_RELEASED;
        endcase
    end

    // Output decode, registered above.
    always_comb begin
        press_d   = (state_q == BTN_RELEASED) && rise;
        release_d = (state_q != BTN_RELEASED) && fall;
        long_d    = long_hit || rep_hit;
    end

    // Long counter runs only while PRESSED; FSM leaves PRESSED before overflow.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            long_cnt <= '0;
        else if (state_q == BTN_PRESSED && !fall)
            long_cnt <= long_cnt + CNT_W'(1);
        else
            long_cnt <= '0;
    end

`ifdef BTN_AUTOREPEAT_EN
    logic [CNT_W-1:0] rep_cnt;

    assign rep_hit = (state_q == BTN_HELD) && !fall &&
                     (rep_cnt == CNT_W'(REPEAT_CYCLES - 1));

    // Repeat counter: zero on HELD entry, wraps every REPEAT_CYCLES.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            rep_cnt <= '0;
        else if (state_q != BTN_HELD || fall || rep_hit)
            rep_cnt <= '0;
        else
            rep_cnt <= rep_cnt + CNT_W'(1);
    end
`else
    assign rep_hit = 1'b0;
`endif

endmodule

// File: rtl/btn_reader.sv
// btn_reader: N_BTN independent debounced button channels.
// Optional macro BTN_AUTOREPEAT_EN enables long_pulse auto-repeat in HELD.
module btn_reader
    import btn_pkg::*;
#(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    btn_reader_if.master bus
);

    logic [N_BTN-1:0] state_w, press_w, release_w, long_w;

    // One channel instance per button.
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .sys_clk       (sys_clk),
            .sys_rst_n     (sys_rst_n),
            .btn_n         (bus.btn_n[i]),
            .btn_state     (state_w[i]),
            .press_pulse   (press_w[i]),
            .release_pulse (release_w[i]),
            .long_pulse    (long_w[i])
        );
    end

    assign bus.btn_state     = state_w;
    assign bus.press_pulse   = press_w;
    assign bus.release_pulse = release_w;
    assign bus.long_pulse    = long_w;

endmodule

// File: tb/tb_btn_reader.sv
// tb_btn_reader: directed + randomized stimulus against a window-based
// behavioural model of debounce and press timing.
module tb_btn_reader;

    localparam int N = 2;
    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 8;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    btn_reader_if #(.N_BTN(N)) bus ();

    btn_reader #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .REPEAT_CYCLES   (R)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int press_t [N];

    logic [N-1:0] hist [$];      // pin value captured at each active edge
    logic [N-1:0] acc;           // level accepted by the filter
    logic [N-1:0] exp_state, exp_press, exp_rel, exp_long;

    // Pin value 'back' edges ago; before history (reset) the pin reads released.
    function automatic logic pin_at(int ch, int back);
        int idx;
        idx = hist.size() - 1 - back;
        if (idx < 0) return 1'b1;
        return hist[idx][ch];
    endfunction

    task automatic model_reset();
        hist.delete();
        acc       = '0;
        exp_state = '0;
        exp_press = '0;
        exp_rel   = '0;
        exp_long  = '0;
    endtask

    // Rules: the filter at edge t sees the pin captured at t-2; the level flips
    // once the last D seen samples all disagree with it; btn_state shows the
    // accepted level one cycle later. Long pulse at press age L-1 (and every R
    // afterwards with auto-repeat) while still pressed.
    task automatic model_edge();
        cyc++;
        for (int ch = 0; ch < N; ch++) begin
            logic nst;
            logic flip;
            int   age;
            nst  = acc[ch];
            flip = 1'b1;
            for (int j = 0; j < D; j++)
                if (~pin_at(ch, 2 + j) == acc[ch]) flip = 1'b0;
            exp_press[ch] = nst & ~exp_state[ch];
            exp_rel[ch]   = ~nst & exp_state[ch];
            if (exp_press[ch]) press_t[ch] = cyc;
            exp_long[ch] = 1'b0;
            if (nst) begin
                age = cyc - press_t[ch];
                if (age == L - 1) exp_long[ch] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                if (age > L - 1 && ((age - (L - 1)) % R) == 0) exp_long[ch] = 1'b1;
`endif
            end
            exp_state[ch] = nst;
            acc[ch]       = acc[ch] ^ flip;
        end
    endtask

    task automatic check();
        vectors++;
        assert (bus.btn_state === exp_state) else begin
            miscompares++;
            $error("FAIL btn_state cyc=%0d got=%b want=%b", cyc, bus.btn_state, exp_state);
        end
        vectors++;
        assert (bus.press_pulse === exp_press) else begin
            miscompares++;
            $error("FAIL press_pulse cyc=%0d got=%b want=%b", cyc, bus.press_pulse, exp_press);
        end
        vectors++;
        assert (bus.release_pulse === exp_rel) else begin
            miscompares++;
            $error("FAIL release_pulse cyc=%0d got=%b want=%b", cyc, bus.release_pulse, exp_rel);
        end
        vectors++;
        assert (bus.long_pulse === exp_long) else begin
            miscompares++;
            $error("FAIL long_pulse cyc=%0d got=%b want=%b", cyc, bus.long_pulse, exp_long);
        end
    endtask

    // Called at a falling edge: drive pins, advance one clock, check at next fall.
    task automatic tick(input logic [N-1:0] pins);
        bus.btn_n = pins;
        @(posedge sys_clk);
        if (sys_rst_n) begin
            hist.push_back(pins);
            model_edge();
        end else begin
            model_reset();
        end
        @(negedge sys_clk);
        check();
    endtask

    task automatic hold(input logic [N-1:0] pins, input int n);
        repeat (n) tick(pins);
    endtask

    initial begin
        int           run [N];
        logic [N-1:0] p;

        bus.btn_n = '1;
        model_reset();
        @(negedge sys_clk);
        check();                       // reset state
        hold('1, 3);
        sys_rst_n = 1'b1;
        hold('1, 5);

        // clean press on channel 0
        hold(2'b10, 10);
        hold(2'b11, 12);

        // bounce shorter than the filter
        for (int k = 0; k < 10; k++) hold((k % 2) ? 2'b11 : 2'b10, 2);
        hold(2'b11, 12);

        // long press, then release
        hold(2'b10, 6 + 30);
        hold(2'b11, 12);

        // hold long enough for several repeat periods
        hold(2'b10, 6 + 44);
        hold(2'b11, 12);

        // reset while PRESSED, button kept down through and after reset
        hold(2'b10, 6 + 5);
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        check();                       // async clear without waiting for a clock
        hold(2'b10, 3);
        sys_rst_n = 1'b1;
        hold(2'b10, 12);
        hold(2'b11, 12);

        // both channels pressed together
        hold(2'b00, 10);
        hold(2'b11, 12);

        // independent random activity on both channels
        p = '1;
        for (int ch = 0; ch < N; ch++) run[ch] = $urandom_range(1, 10);
        for (int c = 0; c < 600; c++) begin
            for (int ch = 0; ch < N; ch++) begin
                if (run[ch] == 0) begin
                    p[ch]   = ~p[ch];
                    run[ch] = ($urandom_range(0, 2) == 0) ? $urandom_range(20, 45)
                                                          : $urandom_range(1, 8);
                end
                run[ch]--;
            end
            tick(p);
        end
        hold('1, 15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/btn_reader.md
Name: btn_reader

Overview:
- Input-side counterpart to the LED pattern driver: reads the board's active-low user push-buttons and turns them into clean, debounced levels and single-cycle events.
- Per channel: 2-flop synchroniser, debounce filter, then a press-classification FSM that produces press, release and long-press pulses.
- Sits between the top-level button pins and the LED/mode control logic, which consumes the pulses. Runs in the 24 MHz system domain.

Parameters:
- N_BTN, 2, number of button channels.
- DEBOUNCE_CYCLES, 240_000, consecutive stable samples needed to accept a level change (10 ms at 24 MHz); must be >=2.
- LONG_CYCLES, 24_000_000, debounced-pressed duration that qualifies as a long press (1 s); must be > DEBOUNCE_CYCLES.
- REPEAT_CYCLES, 6_000_000, auto-repeat period (250 ms); used only with the optional feature.

Ports:
- sys_clk  input  1  24 MHz system clock.
- sys_rst_n  input  1  asynchronous active-low reset.
- btn_n  input  N_BTN  raw button pins, active-low, asynchronous to sys_clk.
- btn_state  output  N_BTN  debounced level, 1 = pressed.
- press_pulse  output  N_BTN  1-cycle pulse on accepted press.
- release_pulse  output  N_BTN  1-cycle pulse on accepted release.
- long_pulse  output  N_BTN  1-cycle pulse when a press reaches LONG_CYCLES (also repeat pulses, see optional feature).

Behaviour:
- Reset (sys_rst_n low, asynchronous): synchroniser flops = 1 (released), debounce counters = 0, btn_state = 0, all pulses = 0, FSM = RELEASED, long counter = 0. Reset mid-press yields no pulses; after reset release, a still-held button is re-detected as a new press after full debounce.
- Synchroniser: two flops per channel; the second flop's output, inverted, is the sampled level s[i].
- Debounce: the counter increments each cycle while s[i] != btn_state[i] and clears to 0 when they are equal. When it reaches DEBOUNCE_CYCLES-1 while still mismatched, btn_state[i] toggles on the next edge and the counter clears.
  - Latency: btn_state changes DEBOUNCE_CYCLES+2 cycles after the first edge that samples a clean pin change.
  - A glitch shorter than DEBOUNCE_CYCLES never changes btn_state.
- FSM per channel: RELEASED, PRESSED, HELD.
  - RELEASED -> PRESSED: btn_state rises. press_pulse is high in the first cycle btn_state reads 1. The long counter clears.
  - PRESSED: the long counter increments each cycle. At LONG_CYCLES-1, long_pulse is asserted for one cycle and the FSM goes to HELD.
  - PRESSED/HELD -> RELEASED: btn_state falls. release_pulse is high in the first cycle btn_state reads 0. Counters clear.
  - Release in the same cycle the long threshold would be hit: release wins; no long_pulse.
- Counter widths are $clog2(max threshold + 1) and saturate-free, because the FSM bounds them. No wrap-around is possible.
- Channels are fully independent; simultaneous events on different channels each pulse in their own bit.
- All outputs are registered; no combinational path from btn_n to any output.

Optional Feature:
- Macro BTN_AUTOREPEAT_EN.
- Defined: in HELD, a repeat counter runs and long_pulse re-asserts for one cycle every REPEAT_CYCLES while the button stays pressed. The counter clears on entry to HELD and on release.
- Undefined: HELD is terminal until release; exactly one long_pulse per press; no repeat counter logic is generated.

Decomposition:
- Shared package btn_pkg holds the FSM state encoding (RELEASED=2'd0, PRESSED=2'd1, HELD=2'd2) and the default timing constants derived from the 24 MHz clock.
- One sub-module, btn_channel, covers synchroniser, debounce and FSM for a single button. btn_reader generates N_BTN instances.

Test Plan (bench params DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8):
- Clean press: btn_n[0] 1->0 held 10 cycles -> btn_state[0]=1 exactly 6 cycles after the sampling edge; press_pulse[0] is one cycle in that same cycle; no other pulses.
- Bounce rejection: btn_n[0] toggles 0/1 every 2 cycles for 20 cycles, then stays 1 -> btn_state stays 0; zero pulses.
- Long press: hold 30 cycles past acceptance -> one long_pulse 19 cycles after press_pulse. Release -> release_pulse 6 cycles after the pin returns to 1.
- Auto-repeat (macro defined): hold 50 cycles past acceptance -> long_pulse at +19, +27, +35, +43. Without the macro: only the pulse at +19.
- Reset mid-press: assert sys_rst_n=0 while in PRESSED with btn held; release reset -> all outputs 0 during reset; no release_pulse; new press_pulse 6 cycles after reset deassertion.
- Two channels: press btn_n[0] and btn_n[1] on the same cycle -> press_pulse=2'b11 in a single cycle.
